// File: rtl/rsa_core_pkg.sv
// rsa_core_pkg: shared FSM states, error codes and mode encodings for the RSA modular-multiply core.
package rsa_core_pkg;

    typedef enum logic [2:0] {IDLE, CHECK, RUN, DONE, ERROR} state_t;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_ZERO_N = 2'b01;
    localparam logic [1:0] ERR_RANGE  = 2'b10;

    localparam logic MODE_REDUCE = 1'b0;
    localparam logic MODE_MULT   = 1'b1;

endpackage

// File: rtl/rsa_core_modmul_if.sv
// rsa_core_modmul_if: request/result bundle between a requester and the modular-multiply core.
interface rsa_core_modmul_if #(
    parameter int DATA_WIDTH = 8
);

    logic                      mm_start;
    logic                      mm_mode;
    logic [2*DATA_WIDTH-1:0]   mm_a;
    logic [DATA_WIDTH-1:0]     mm_x;
    logic [DATA_WIDTH-1:0]     mm_y;
    logic [DATA_WIDTH-1:0]     mm_n;
    logic                      mm_busy;
    logic                      mm_done;
    logic                      mm_err;
    logic [1:0]                mm_err_code;
    logic [DATA_WIDTH-1:0]     mm_c;

    modport master (
        output mm_start, mm_mode, mm_a, mm_x, mm_y, mm_n,
        input  mm_busy, mm_done, mm_err, mm_err_code, mm_c
    );

    modport slave (
        input  mm_start, mm_mode, mm_a, mm_x, mm_y, mm_n,
        output mm_busy, mm_done, mm_err, mm_err_code, mm_c
    );

endinterface

// File: rtl/rsa_core_csub.sv
// rsa_core_csub: (W+1)-bit compare against the modulus and subtract it once when v >= n.
module rsa_core_csub #(
    parameter int W = 8
) (
    input  logic [W:0]   v,
    input  logic [W-1:0] n,
    output logic [W:0]   r
);

    assign r = (v >= {1'b0, n}) ? v - {1'b0, n} : v;

endmodule

// File: rtl/rsa_core_modmul.sv
// rsa_core_modmul: bit-serial A mod N reduction and X*Y mod N multiplication, one operand bit per cycle.
module rsa_core_modmul
    import rsa_core_pkg::*;
#(
    parameter int   DATA_WIDTH = 8,
    parameter logic START      = 1'b1
) (
    input  logic               mm_clk,
    input  logic               mm_rst,
    rsa_core_modmul_if.slave   mm_if
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(2 * W + 1);

    state_t          state, state_nx;
    logic            mode_q;
    logic [2*W-1:0]  op_q;
    logic [W-1:0]    x_q;
    logic [W-1:0]    n_q;
    logic [W:0]      r_q;
    logic [CW-1:0]   cnt_q;
    logic [W-1:0]    c_q;
    logic            err_q;
    logic [1:0]      code_q;

    logic            accept;
    logic            zero_n;
    logic            range_err;
    logic            bit_in;
    logic [W:0]      shifted;
    logic [W:0]      s1;
    logic [W:0]      addend;
    logic [W:0]      sum;
    logic [W:0]      r_nx;

    assign accept    = state == IDLE && mm_if.mm_start == START;
    assign zero_n    = n_q == '0;
    // in multiply mode Y sits in the upper half of op_q until RUN starts shifting it out
    assign range_err = mode_q == MODE_MULT && (x_q >= n_q || op_q[2*W-1:W] >= n_q);

    // one shared step: reduce shifts in the next A bit and adds nothing,
    // multiply shifts in zero and adds X when the current Y bit is set
    assign bit_in  = mode_q == MODE_REDUCE && op_q[2*W-1];
    assign shifted = (r_q << 1) | {{W{1'b0}}, bit_in};
    assign addend  = (mode_q == MODE_MULT && op_q[2*W-1]) ? {1'b0, x_q} : '0;
    assign sum     = s1 + addend;

    rsa_core_csub #(.W(W)) u_csub_shift (
        .v (shifted),
        .n (n_q),
        .r (s1)
    );

    rsa_core_csub #(.W(W)) u_csub_add (
        .v (sum),
        .n (n_q),
        .r (r_nx)
    );

    always_ff @(posedge mm_clk or negedge mm_rst) begin
        if (!mm_rst) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = accept ? CHECK : IDLE;
            CHECK:   state_nx = (zero_n || range_err) ? ERROR : RUN;
            RUN:     state_nx = (cnt_q == CW'(1)) ? DONE : RUN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge mm_clk or negedge mm_rst) begin
        if (!mm_rst) begin
            mode_q <= MODE_REDUCE;
            op_q   <= '0;
            x_q    <= '0;
            n_q    <= '0;
            r_q    <= '0;
            cnt_q  <= '0;
            c_q    <= '0;
            err_q  <= 1'b0;
            code_q <= ERR_NONE;
        end else if (accept) begin
            mode_q <= mm_if.mm_mode;
            op_q   <= (mm_if.mm_mode == MODE_MULT) ? {mm_if.mm_y, {W{1'b0}}} : mm_if.mm_a;
            x_q    <= mm_if.mm_x;
            n_q    <= mm_if.mm_n;
        end else if (state == CHECK) begin
            r_q   <= '0;
            cnt_q <= (mode_q == MODE_MULT) ? CW'(W) : CW'(2 * W);
            if (zero_n || range_err) begin
                c_q    <= '1;
                err_q  <= 1'b1;
                code_q <= zero_n ? ERR_ZERO_N : ERR_RANGE;
            end
        end else if (state == RUN) begin
            r_q   <= r_nx;
            op_q  <= op_q << 1;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                c_q    <= r_nx[W-1:0];
                err_q  <= 1'b0;
                code_q <= ERR_NONE;
            end
        end
    end

    assign mm_if.mm_busy     = state != IDLE;
    assign mm_if.mm_done     = state == DONE || state == ERROR;
    assign mm_if.mm_c        = c_q;
    assign mm_if.mm_err      = err_q;
    assign mm_if.mm_err_code = code_q;

endmodule

// File: tb/tb_rsa_core_modmul.sv
// tb_rsa_core_modmul: scoreboard bench for the modular-multiply core at W=8.
module tb_rsa_core_modmul;

    typedef struct {
        logic [7:0] c;
        logic       err;
        logic [1:0] code;
        int         lat;
    } exp_t;

    logic mm_clk = 1'b0;
    logic mm_rst = 1'b0;
    int   n_vec  = 0;
    int   n_err  = 0;
    exp_t sb[$];

    always #5 mm_clk = ~mm_clk;

    rsa_core_modmul_if #(.DATA_WIDTH(8)) bus ();

    rsa_core_modmul #(.DATA_WIDTH(8), .START(1'b1)) dut (
        .mm_clk (mm_clk),
        .mm_rst (mm_rst),
        .mm_if  (bus)
    );

    function automatic exp_t model(input logic m, input logic [15:0] a, input logic [7:0] x, y, n);
        exp_t e;
        if (n == 8'h00) begin
            e.c = 8'hFF; e.err = 1'b1; e.code = 2'b01; e.lat = 2;
        end else if (m && (x >= n || y >= n)) begin
            e.c = 8'hFF; e.err = 1'b1; e.code = 2'b10; e.lat = 2;
        end else begin
            e.c    = m ? 8'((32'(x) * 32'(y)) % 32'(n)) : 8'(32'(a) % 32'(n));
            e.err  = 1'b0;
            e.code = 2'b00;
            e.lat  = m ? 10 : 18;
        end
        return e;
    endfunction

    // starts at the negedge of the first cycle after accept; optionally pokes start at cycle `poke`
    task automatic wait_done(input int poke, output int lat, output bit to);
        lat = 0;
        to  = 1'b1;
        repeat (40) begin
            lat++;
            if (bus.mm_done) begin
                to = 1'b0;
                break;
            end
            bus.mm_start = (lat == poke);
            @(negedge mm_clk);
        end
        bus.mm_start = 1'b0;
    endtask

    task automatic run_op(input logic m, input logic [15:0] a, input logic [7:0] x, y, n,
                          input int poke, output int lat, output bit to);
        sb.push_back(model(m, a, x, y, n));
        @(negedge mm_clk);
        bus.mm_start = 1'b1; bus.mm_mode = m; bus.mm_a = a; bus.mm_x = x; bus.mm_y = y; bus.mm_n = n;
        @(posedge mm_clk);
        @(negedge mm_clk);
        bus.mm_start = 1'b0; bus.mm_mode = ~m; bus.mm_a = ~a; bus.mm_x = ~x; bus.mm_y = ~y; bus.mm_n = ~n;
        wait_done(poke, lat, to);
    endtask

    task automatic test_reset();
        mm_rst = 1'b0;
        repeat (3) @(negedge mm_clk);
        n_vec++;
        if ({bus.mm_busy, bus.mm_done, bus.mm_err, bus.mm_err_code, bus.mm_c} !== 13'h0) begin
            n_err++;
            $display("FAIL reset: busy=%b done=%b err=%b code=%b c=%h, expected all zero",
                     bus.mm_busy, bus.mm_done, bus.mm_err, bus.mm_err_code, bus.mm_c);
        end
        mm_rst = 1'b1;
    endtask

    task automatic test_vectors();
        logic        tm[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [15:0] ta[6] = '{16'h1234, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h1234, 16'h0000};
        logic [7:0]  tx[6] = '{8'h00, 8'h35, 8'h00, 8'h00, 8'h00, 8'h70};
        logic [7:0]  ty[6] = '{8'h00, 8'h4B, 8'h00, 8'h00, 8'h00, 8'h01};
        logic [7:0]  tn[6] = '{8'h61, 8'h61, 8'hFF, 8'h01, 8'h00, 8'h61};
        int lat;
        bit to;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            run_op(tm[i], ta[i], tx[i], ty[i], tn[i], 0, lat, to);
            e = sb.pop_front();
            n_vec++;
            if (to || bus.mm_c !== e.c || bus.mm_err !== e.err || bus.mm_err_code !== e.code ||
                bus.mm_busy !== 1'b1 || lat != e.lat) begin
                n_err++;
                $display("FAIL vector%0d: c=%h err=%b code=%b busy=%b lat=%0d timeout=%0b, expected c=%h err=%b code=%b busy=1 lat=%0d",
                         i, bus.mm_c, bus.mm_err, bus.mm_err_code, bus.mm_busy, lat, to, e.c, e.err, e.code, e.lat);
            end
        end
    endtask

    task automatic test_err_hold();
        repeat (3) @(negedge mm_clk);
        n_vec++;
        if (bus.mm_done !== 1'b0 || bus.mm_busy !== 1'b0 || bus.mm_err !== 1'b1 ||
            bus.mm_err_code !== 2'b10 || bus.mm_c !== 8'hFF) begin
            n_err++;
            $display("FAIL err_hold: done=%b busy=%b err=%b code=%b c=%h, expected done=0 busy=0 err=1 code=10 c=ff",
                     bus.mm_done, bus.mm_busy, bus.mm_err, bus.mm_err_code, bus.mm_c);
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        bit to;
        bit seen;
        exp_t e;
        run_op(1'b0, 16'h1234, 8'h00, 8'h00, 8'h61, 7, lat, to);
        e = sb.pop_front();
        n_vec++;
        if (to || bus.mm_c !== e.c || bus.mm_err !== e.err || lat != e.lat) begin
            n_err++;
            $display("FAIL ignore_start: c=%h err=%b lat=%0d timeout=%0b, expected c=%h err=%b lat=%0d",
                     bus.mm_c, bus.mm_err, lat, to, e.c, e.err, e.lat);
        end
        seen = 1'b0;
        repeat (25) begin
            @(negedge mm_clk);
            if (bus.mm_done || bus.mm_busy) seen = 1'b1;
        end
        n_vec++;
        if (seen) begin
            n_err++;
            $display("FAIL ignore_queue: activity=1 after mid-run start, expected 0");
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit to;
        bit seen;
        exp_t e;
        @(negedge mm_clk);
        bus.mm_start = 1'b1; bus.mm_mode = 1'b0; bus.mm_a = 16'h1234; bus.mm_n = 8'h61;
        @(posedge mm_clk);
        @(negedge mm_clk);
        bus.mm_start = 1'b0;
        repeat (5) @(negedge mm_clk);
        mm_rst = 1'b0;
        #1;
        n_vec++;
        if ({bus.mm_busy, bus.mm_done, bus.mm_err, bus.mm_err_code, bus.mm_c} !== 13'h0) begin
            n_err++;
            $display("FAIL reset_mid: busy=%b done=%b err=%b code=%b c=%h, expected all zero",
                     bus.mm_busy, bus.mm_done, bus.mm_err, bus.mm_err_code, bus.mm_c);
        end
        @(negedge mm_clk);
        mm_rst = 1'b1;
        seen = 1'b0;
        repeat (25) begin
            @(negedge mm_clk);
            if (bus.mm_done) seen = 1'b1;
        end
        n_vec++;
        if (seen) begin
            n_err++;
            $display("FAIL reset_abort: done=1 after aborted operation, expected 0");
        end
        run_op(1'b1, 16'h0000, 8'h35, 8'h4B, 8'h61, 0, lat, to);
        e = sb.pop_front();
        n_vec++;
        if (to || bus.mm_c !== e.c || bus.mm_err !== e.err || bus.mm_err_code !== e.code || lat != e.lat) begin
            n_err++;
            $display("FAIL after_reset: c=%h err=%b code=%b lat=%0d timeout=%0b, expected c=%h err=%b code=%b lat=%0d",
                     bus.mm_c, bus.mm_err, bus.mm_err_code, lat, to, e.c, e.err, e.code, e.lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit to;
        exp_t e;
        sb.push_back(model(1'b0, 16'h1234, 8'h00, 8'h00, 8'h61));
        sb.push_back(model(1'b1, 16'h0000, 8'h35, 8'h4B, 8'h61));
        @(negedge mm_clk);
        bus.mm_start = 1'b1; bus.mm_mode = 1'b0; bus.mm_a = 16'h1234; bus.mm_n = 8'h61;
        @(posedge mm_clk);
        @(negedge mm_clk);
        bus.mm_mode = 1'b1; bus.mm_a = 16'h0000; bus.mm_x = 8'h35; bus.mm_y = 8'h4B;
        wait_done(-1, lat, to);
        bus.mm_start = 1'b1;
        e = sb.pop_front();
        n_vec++;
        if (to || bus.mm_c !== e.c || bus.mm_err !== e.err || lat != e.lat) begin
            n_err++;
            $display("FAIL b2b_first: c=%h err=%b lat=%0d timeout=%0b, expected c=%h err=%b lat=%0d",
                     bus.mm_c, bus.mm_err, lat, to, e.c, e.err, e.lat);
        end
        @(negedge mm_clk);
        n_vec++;
        if (bus.mm_busy !== 1'b0 || bus.mm_done !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_idle: busy=%b done=%b, expected busy=0 done=0", bus.mm_busy, bus.mm_done);
        end
        @(posedge mm_clk);
        @(negedge mm_clk);
        bus.mm_start = 1'b0;
        wait_done(0, lat, to);
        e = sb.pop_front();
        n_vec++;
        if (to || bus.mm_c !== e.c || bus.mm_err !== e.err || lat != e.lat) begin
            n_err++;
            $display("FAIL b2b_second: c=%h err=%b lat=%0d timeout=%0b, expected c=%h err=%b lat=%0d",
                     bus.mm_c, bus.mm_err, lat, to, e.c, e.err, e.lat);
        end
    endtask

    task automatic test_random();
        int lat;
        bit to;
        exp_t e;
        logic        m;
        logic [15:0] a;
        logic [7:0]  x, y, n;
        for (int i = 0; i < 24; i++) begin
            m = 1'($urandom_range(0, 1));
            a = 16'($urandom);
            n = 8'($urandom_range(1, 255));
            x = 8'($urandom_range(0, 32'(n) - 1));
            y = 8'($urandom_range(0, 32'(n) - 1));
            if (i % 8 == 5) n = 8'h00;
            if (i % 8 == 6) y = 8'hFF;
            run_op(m, a, x, y, n, 0, lat, to);
            e = sb.pop_front();
            n_vec++;
            if (to || bus.mm_c !== e.c || bus.mm_err !== e.err || bus.mm_err_code !== e.code || lat != e.lat) begin
                n_err++;
                $display("FAIL random%0d m=%b a=%h x=%h y=%h n=%h: c=%h err=%b code=%b lat=%0d timeout=%0b, expected c=%h err=%b code=%b lat=%0d",
                         i, m, a, x, y, n, bus.mm_c, bus.mm_err, bus.mm_err_code, lat, to, e.c, e.err, e.code, e.lat);
            end
        end
    endtask

    initial begin
        bus.mm_start = 1'b0; bus.mm_mode = 1'b0; bus.mm_a = '0; bus.mm_x = '0; bus.mm_y = '0; bus.mm_n = '0;
        test_reset();
        test_vectors();
        test_err_hold();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule

// File: doc/rsa_core_modmul.md
RSA_CORE_MODMUL -- requirements
Module: rsa_core_modmul

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, operand/modulus width W (legal W >= 2).
REQ-002 SHALL have parameter START, default 1, active level of mm_start.
REQ-003 SHALL have port mm_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port mm_rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port mm_start, input, 1, request; accepted only when it equals START while in IDLE.
REQ-006 SHALL have port mm_mode, input, 1: 0 = reduce (A mod N), 1 = modular multiply (X*Y mod N).
REQ-007 SHALL have port mm_a, input, 2W, dividend for mode 0; ignored in mode 1.
REQ-008 SHALL have port mm_x, input, W, multiplicand for mode 1.
REQ-009 SHALL have port mm_y, input, W, multiplier for mode 1.
REQ-010 SHALL have port mm_n, input, W, modulus.
REQ-011 SHALL have port mm_busy, output, 1, high from the accept edge until the DONE or ERROR cycle ends.
REQ-012 SHALL have port mm_done, output, 1, one-cycle completion pulse.
REQ-013 SHALL have port mm_err, output, 1, valid with mm_done; 1 = failed.
REQ-014 SHALL have port mm_err_code, output, 2: 00 none, 01 zero modulus, 10 mode-1 operand out of range.
REQ-015 SHALL have port mm_c, output, W, result; held until the next mm_done.

Function
REQ-016 SHALL use the FSM states IDLE, CHECK, RUN, DONE and ERROR.
REQ-017 SHALL, on the accept edge (IDLE with mm_start == START), capture mode, a, x, y and n into internal registers; subsequent input changes SHALL NOT affect the operation.
REQ-018 SHALL, in CHECK (1 cycle), go to ERROR with code 01 if N == 0, else to ERROR with code 10 if mode 1 and (X >= N or Y >= N), else to RUN with R = 0 and iteration counter I (mode 0: 2W, mode 1: W).
REQ-019 SHALL, in mode 0, process A MSB-first, one bit per RUN cycle: R = 2R + a[i]; if R >= N then R = R - N.
REQ-020 SHALL, in mode 1, process Y MSB-first, one bit per RUN cycle: R = 2R, conditional subtract of N; if y[i] then R = R + X, conditional subtract of N.
REQ-021 SHALL hold R at W+1 bits, with comparisons and subtractions at W+1 bits; no intermediate value exceeds 2N-1.
REQ-022 SHALL enter DONE after the I-th RUN cycle, load mm_c = R[W-1:0], and pulse mm_done = 1, mm_err = 0, mm_err_code = 00; the next state is IDLE.
REQ-023 SHALL, in ERROR, load mm_c = all ones, pulse mm_done = 1 and mm_err = 1, and drive mm_err_code per REQ-018; the next state is IDLE.
REQ-024 SHALL set latency from the accept edge to the mm_done-high cycle to I+2 cycles: mode 0 = 2W+2, mode 1 = W+2, error = 2.
REQ-025 SHALL ignore mm_start outside IDLE; requests are not queued.
REQ-026 SHALL allow a start held at START through DONE to be re-accepted in the first IDLE cycle, giving back-to-back operations with one idle cycle between them.
REQ-027 SHALL hold mm_err and mm_err_code until the next mm_done.

Reset
REQ-028 SHALL, on mm_rst low, immediately force state = IDLE, mm_busy = 0, mm_done = 0, mm_err = 0, mm_err_code = 00, mm_c = 0, and R and the counter to 0.
REQ-029 SHALL, on reset asserted mid-operation, abort without a done pulse; the first accept after release starts cleanly.

Structure
REQ-030 SHALL place the state encodings, error-code constants and mode constants in a shared package, rsa_core_pkg.
REQ-031 SHALL implement the (W+1)-bit compare-and-conditional-subtract in a sub-module, rsa_core_csub, instantiated twice (post-shift and post-add).

Verification
REQ-032 SHALL check (W=8): mode 0, A=0x1234, N=0x61 -> mm_c=0x04, err=0, done 18 cycles after accept.
REQ-033 SHALL check: mode 1, X=0x35, Y=0x4B, N=0x61 -> mm_c=0x5F, done 10 cycles after accept.
REQ-034 SHALL check: mode 0, A=0xFFFF, N=0xFF -> mm_c=0x00; and N=0x01 -> mm_c=0x00.
REQ-035 SHALL check: N=0x00 -> done 2 cycles after accept, err=1, code=01, mm_c=0xFF; mode 1, X=0x70, N=0x61 -> code=10.
REQ-036 SHALL check: start pulsed mid-RUN -> ignored, original result unchanged; mm_rst low at RUN cycle 5 -> no done, all outputs zero, next operation correct.
